fe_de_instr_buffer: RTL and testbench
=====================================

Name: fe_de_instr_buffer

Overview:
- Small FIFO that decouples fetch from decode. It sits directly downstream of the fetch-stage program counter and instruction memory read, and directly upstream of the decode stage.
- Captures PC/instruction pairs with a valid/ready handshake, absorbs decode stalls without losing fetched words, and supports a single-cycle flush on branch/jump redirect.

Parameters:
- DEPTH, 2, number of buffered PC/instruction entries; legal range 2..8.
- XLEN, 32, width of PC and instruction words.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  discard all buffered entries (redirect from execute).
- fe_valid  input  1  fetch presents a valid PC/instruction this cycle.
- fe_pc  input  XLEN  PC of presented instruction.
- fe_instr  input  XLEN  instruction word read at fe_pc.
- fe_ready  output  1  buffer can accept an entry this cycle.
- de_valid  output  1  head entry valid toward decode.
- de_pc  output  XLEN  PC of head entry.
- de_pc_plus4  output  XLEN  de_pc + 4, modulo 2^XLEN.
- de_instr  output  XLEN  instruction of head entry.
- de_misaligned  output  1  de_pc[1:0] != 2'b00 for the head entry.
- de_ready  input  1  decode consumes head entry this cycle.

Behaviour:
Reset:
- rst low clears, asynchronously: count, read pointer, write pointer, and all storage.
- Reset values: fe_ready=1, de_valid=0, de_pc=0, de_pc_plus4=4, de_instr=0, de_misaligned=0.
- Reset asserted mid-operation discards every entry immediately, with no completion of an in-flight push or pop.

Storage and pointers:
- Circular array of DEPTH entries (pc, instr).
- Write and read pointers wrap from DEPTH-1 to 0.
- count is $clog2(DEPTH+1) bits wide, range 0..DEPTH.

Handshake and flags:
- push = fe_valid && fe_ready; pop = de_valid && de_ready.
- fe_ready = (count < DEPTH), driven from registered state only, with no combinational path from de_ready.
- de_valid = (count != 0); the de_* outputs show the entry at the read pointer.

Latency and throughput:
- An entry pushed in cycle N appears at the outputs in cycle N+1 at the earliest; there is no same-cycle bypass.
- Push and pop in the same cycle with 0 < count < DEPTH leave count unchanged and advance both pointers, giving one entry per cycle sustained.

Boundary conditions:
- Full (count=DEPTH): fe_ready=0, and fe_valid is ignored. A pop in that cycle drops count to DEPTH-1, so fe_ready=1 the next cycle.
- Empty: pop cannot occur because de_valid=0. A push makes count=1.
- Flush has priority over push and pop. With flush=1 at a rising edge: count, read pointer and write pointer go to 0, any simultaneous push is discarded, and de_valid=0 the next cycle. The following cycle resumes normal operation, so the first post-flush fe_valid is accepted.

Outputs and arithmetic:
- de_pc_plus4 is computed combinationally from the head pc and wraps modulo 2^XLEN (0xFFFFFFFC -> 0x00000000).
- de_misaligned is combinational from the head pc.
- When empty, de_pc, de_pc_plus4 and de_misaligned reflect stale storage and carry no meaning. Decode qualifies them with de_valid. de_instr is defined under Optional Feature.

Optional Feature:
- Macro: FE_DE_BUBBLE_NOP_EN.
- Defined: when de_valid=0, de_instr is forced to 32'h00000013 (addi x0,x0,0) and de_misaligned to 0, so decode can consume bubbles unconditionally. Reset value of de_instr is 32'h00000013.
- Undefined: when de_valid=0, de_instr is forced to 32'h00000000. Reset value is 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles with fe_valid=1 -> fe_ready=1, de_valid=0, de_pc=0, de_pc_plus4=4, de_instr=0 (0x13 with macro).
- Streaming: de_ready=1, push pc 0x0,0x4,0x8 with instrs 0xA,0xB,0xC on consecutive cycles -> de_valid=1 from the cycle after the first push, de_pc 0x0,0x4,0x8 on consecutive cycles, count never exceeds 1.
- Stall/full (DEPTH=2): de_ready=0, push 0x10,0x14 -> fe_ready=0 after the second push and a third fe_valid (0x18) is ignored. Raise de_ready -> outputs 0x10 then 0x14, fe_ready returns to 1 one cycle after the first pop.
- Flush priority: buffer holds 2 entries, assert flush together with fe_valid (pc 0x40) and de_ready=1 -> de_valid=0 next cycle, 0x40 never appears. Push 0x80 the cycle after -> de_pc=0x80 one cycle later.
- Wrap and arithmetic: push pc 0xFFFFFFFC -> de_pc_plus4=0x00000000. Push pc 0x00000102 -> de_misaligned=1. Run more than 3×DEPTH push/pop cycles -> pointer wrap leaves FIFO order intact.
- Async reset mid-stream: drop rst between clock edges with 2 entries held -> de_valid=0 and fe_ready=1 immediately, before the next edge.

Source files
------------

// File: rtl/fe_de_instr_buffer.sv
// Fetch-to-decode PC/instruction FIFO with valid/ready handshakes and single-cycle flush.
// Optional macro FE_DE_BUBBLE_NOP_EN: empty buffer presents addi x0,x0,0 and a clear misaligned flag.
module fe_de_instr_buffer #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            fe_valid,
   input  logic [XLEN-1:0] fe_pc,
   input  logic [XLEN-1:0] fe_instr,
   output logic            fe_ready,
   output logic            de_valid,
   output logic [XLEN-1:0] de_pc,
   output logic [XLEN-1:0] de_pc_plus4,
   output logic [XLEN-1:0] de_instr,
   output logic            de_misaligned,
   input  logic            de_ready
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
`ifdef FE_DE_BUBBLE_NOP_EN
   localparam logic [XLEN-1:0] BUBBLE_INSTR = XLEN'(32'h0000_0013);
`else
   localparam logic [XLEN-1:0] BUBBLE_INSTR = '0;
`endif

   logic [CW-1:0]   count_reg, count_next;
   logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [XLEN-1:0] pc_mem_reg    [DEPTH];
   logic [XLEN-1:0] instr_mem_reg [DEPTH];
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_instr;
   logic            push;
   logic            pop;

   // Flags come from registered count only, so de_ready never reaches fe_ready.
   assign fe_ready = (count_reg < FULL_COUNT);
   assign de_valid = (count_reg != '0);
   assign push     = fe_valid && fe_ready;
   assign pop      = de_valid && de_ready;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      count_next  = count_reg;
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      if (flush) begin
         count_next  = '0;
         rd_ptr_next = '0;
         wr_ptr_next = '0;
      end else begin
         if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
         case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
      end else begin
         count_reg  <= count_next;
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
      end
   end

   // Storage is cleared by reset so the head outputs read zero straight after reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               pc_mem_reg[gi]    <= '0;
               instr_mem_reg[gi] <= '0;
            end else if (push && !flush && (wr_ptr_reg == PW'(gi))) begin
               pc_mem_reg[gi]    <= fe_pc;
               instr_mem_reg[gi] <= fe_instr;
            end
         end
      end
   endgenerate

   assign head_pc     = pc_mem_reg[rd_ptr_reg];
   assign head_instr  = instr_mem_reg[rd_ptr_reg];
   assign de_pc       = head_pc;
   assign de_pc_plus4 = head_pc + XLEN'(4);
   assign de_instr    = de_valid ? head_instr : BUBBLE_INSTR;

`ifdef FE_DE_BUBBLE_NOP_EN
   assign de_misaligned = de_valid && (head_pc[1:0] != 2'b00);
`else
   assign de_misaligned = (head_pc[1:0] != 2'b00);
`endif

endmodule

// File: tb/tb_fe_de_instr_buffer.sv
// Directed self-checking bench for fe_de_instr_buffer (DEPTH=2, XLEN=32).
module tb_fe_de_instr_buffer;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;
`ifdef FE_DE_BUBBLE_NOP_EN
   localparam logic [31:0] BUBBLE = 32'h0000_0013;
`else
   localparam logic [31:0] BUBBLE = 32'h0000_0000;
`endif

   logic            clk;
   logic            rst;
   logic            flush;
   logic            fe_valid;
   logic [XLEN-1:0] fe_pc;
   logic [XLEN-1:0] fe_instr;
   logic            fe_ready;
   logic            de_valid;
   logic [XLEN-1:0] de_pc;
   logic [XLEN-1:0] de_pc_plus4;
   logic [XLEN-1:0] de_instr;
   logic            de_misaligned;
   logic            de_ready;

   int errors = 0;
   int checks = 0;

   fe_de_instr_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_instr(fe_instr), .fe_ready(fe_ready),
      .de_valid(de_valid), .de_pc(de_pc), .de_pc_plus4(de_pc_plus4),
      .de_instr(de_instr), .de_misaligned(de_misaligned), .de_ready(de_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; flush = 1'b0; de_ready = 1'b0;
      fe_valid = 1'b1; fe_pc = 32'h123; fe_instr = 32'hDEAD;
      repeat (3) step();
      checks++; if (fe_ready !== 1'b1) begin errors++; $display("FAIL reset_fe_ready got=%b exp=1", fe_ready); end
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL reset_de_valid got=%b exp=0", de_valid); end
      checks++; if (de_pc !== 32'h0) begin errors++; $display("FAIL reset_de_pc got=%h exp=0", de_pc); end
      checks++; if (de_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got=%h exp=4", de_pc_plus4); end
      checks++; if (de_instr !== BUBBLE) begin errors++; $display("FAIL reset_de_instr got=%h exp=%h", de_instr, BUBBLE); end
      checks++; if (de_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got=%b exp=0", de_misaligned); end
      fe_valid = 1'b0;
      rst = 1'b1;
      step();
      $display("reset: fe_ready=%b de_valid=%b de_instr=%h", fe_ready, de_valid, de_instr);
   endtask

   task automatic test_streaming;
      logic [31:0] pcs [3];
      logic [31:0] ins [3];
      pcs = '{32'h0, 32'h4, 32'h8};
      ins = '{32'hA, 32'hB, 32'hC};
      de_ready = 1'b1;
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got=%b exp=0", de_valid); end
      for (int i = 0; i < 3; i++) begin
         fe_valid = 1'b1; fe_pc = pcs[i]; fe_instr = ins[i];
         step();
         checks++; if (de_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, de_valid); end
         checks++; if (de_pc !== pcs[i]) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, de_pc, pcs[i]); end
         checks++; if (de_instr !== ins[i]) begin errors++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, de_instr, ins[i]); end
         checks++; if (fe_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, fe_ready); end
         $display("stream: push pc=%h -> de_pc=%h de_instr=%h", pcs[i], de_pc, de_instr);
      end
      fe_valid = 1'b0;
      step();
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", de_valid); end
      checks++; if (de_instr !== BUBBLE) begin errors++; $display("FAIL stream_bubble got=%h exp=%h", de_instr, BUBBLE); end
   endtask

   task automatic test_stall_full;
      de_ready = 1'b0;
      fe_valid = 1'b1; fe_pc = 32'h10; fe_instr = 32'h1010;
      step();
      checks++; if (fe_ready !== 1'b1) begin errors++; $display("FAIL full_ready1 got=%b exp=1", fe_ready); end
      fe_pc = 32'h14; fe_instr = 32'h1414;
      step();
      checks++; if (fe_ready !== 1'b0) begin errors++; $display("FAIL full_ready2 got=%b exp=0", fe_ready); end
      checks++; if (de_pc !== 32'h10) begin errors++; $display("FAIL full_head got=%h exp=10", de_pc); end
      fe_pc = 32'h18; fe_instr = 32'h1818;
      step();
      checks++; if (fe_ready !== 1'b0) begin errors++; $display("FAIL full_hold got=%b exp=0", fe_ready); end
      de_ready = 1'b1;
      step();
      checks++; if (de_pc !== 32'h14) begin errors++; $display("FAIL full_pop1 got=%h exp=14", de_pc); end
      checks++; if (de_instr !== 32'h1414) begin errors++; $display("FAIL full_pop1_instr got=%h exp=1414", de_instr); end
      checks++; if (fe_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got=%b exp=1", fe_ready); end
      fe_valid = 1'b0;
      step();
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL full_ignored got=%b exp=0", de_valid); end
      $display("stall_full: drained, de_valid=%b fe_ready=%b", de_valid, fe_ready);
   endtask

   task automatic test_flush;
      de_ready = 1'b0;
      fe_valid = 1'b1; fe_pc = 32'h20; fe_instr = 32'h2020;
      step();
      fe_pc = 32'h24; fe_instr = 32'h2424;
      step();
      checks++; if (fe_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull got=%b exp=0", fe_ready); end
      flush = 1'b1; de_ready = 1'b1; fe_pc = 32'h40; fe_instr = 32'h4040;
      step();
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", de_valid); end
      checks++; if (fe_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", fe_ready); end
      flush = 1'b0; de_ready = 1'b0; fe_pc = 32'h80; fe_instr = 32'h8080;
      step();
      checks++; if (de_valid !== 1'b1) begin errors++; $display("FAIL flush_resume_valid got=%b exp=1", de_valid); end
      checks++; if (de_pc !== 32'h80) begin errors++; $display("FAIL flush_resume_pc got=%h exp=80", de_pc); end
      fe_valid = 1'b0; de_ready = 1'b1;
      step();
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL flush_no_0x40 got=%b exp=0", de_valid); end
      $display("flush: resume pc=80 then empty, de_valid=%b", de_valid);
   endtask

   task automatic test_wrap_arith;
      logic [31:0] q [$];
      logic [31:0] pc_ctr;
      bit          mpush, mpop;
      de_ready = 1'b1;
      fe_valid = 1'b1; fe_pc = 32'hFFFF_FFFC; fe_instr = 32'h1;
      step();
      checks++; if (de_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got=%h exp=0", de_pc_plus4); end
      checks++; if (de_misaligned !== 1'b0) begin errors++; $display("FAIL wrap_aligned got=%b exp=0", de_misaligned); end
      fe_pc = 32'h0000_0102; fe_instr = 32'h2;
      step();
      checks++; if (de_misaligned !== 1'b1) begin errors++; $display("FAIL misaligned got=%b exp=1", de_misaligned); end
      checks++; if (de_pc_plus4 !== 32'h106) begin errors++; $display("FAIL misaligned_plus4 got=%h exp=106", de_pc_plus4); end
      fe_valid = 1'b0;
      step();
      // Irregular push/pop pattern against a queue model to exercise pointer wrap.
      pc_ctr = 32'h1000;
      for (int k = 0; k < 16; k++) begin
         fe_valid = (k % 3) != 2;
         de_ready = (k % 4) != 0;
         fe_pc = pc_ctr; fe_instr = ~pc_ctr;
         mpush = fe_valid && (q.size() < DEPTH);
         mpop  = de_ready && (q.size() > 0);
         step();
         if (mpop) void'(q.pop_front());
         if (mpush) begin q.push_back(pc_ctr); pc_ctr = pc_ctr + 32'h4; end
         checks++; if (de_valid !== (q.size() != 0)) begin errors++; $display("FAIL order_valid[%0d] got=%b exp=%b", k, de_valid, q.size() != 0); end
         checks++; if (fe_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL order_ready[%0d] got=%b exp=%b", k, fe_ready, q.size() < DEPTH); end
         if (q.size() != 0) begin
            checks++; if (de_pc !== q[0]) begin errors++; $display("FAIL order_pc[%0d] got=%h exp=%h", k, de_pc, q[0]); end
            checks++; if (de_instr !== ~q[0]) begin errors++; $display("FAIL order_instr[%0d] got=%h exp=%h", k, de_instr, ~q[0]); end
         end
         $display("order[%0d]: push=%b pop=%b de_valid=%b de_pc=%h", k, mpush, mpop, de_valid, de_pc);
      end
      fe_valid = 1'b0; de_ready = 1'b1;
      for (int k = 0; k <= DEPTH && q.size() != 0; k++) begin
         step();
         void'(q.pop_front());
         if (q.size() != 0) begin
            checks++; if (de_pc !== q[0]) begin errors++; $display("FAIL drain_pc[%0d] got=%h exp=%h", k, de_pc, q[0]); end
         end
      end
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL order_drained got=%b exp=0", de_valid); end
   endtask

   task automatic test_async_reset;
      de_ready = 1'b0;
      fe_valid = 1'b1; fe_pc = 32'h200; fe_instr = 32'h2000;
      step();
      fe_pc = 32'h204; fe_instr = 32'h2004;
      step();
      checks++; if (de_valid !== 1'b1) begin errors++; $display("FAIL async_pre_valid got=%b exp=1", de_valid); end
      #1 rst = 1'b0;
      #1;
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%b exp=0", de_valid); end
      checks++; if (fe_ready !== 1'b1) begin errors++; $display("FAIL async_ready got=%b exp=1", fe_ready); end
      checks++; if (de_pc !== 32'h0) begin errors++; $display("FAIL async_pc got=%h exp=0", de_pc); end
      checks++; if (de_instr !== BUBBLE) begin errors++; $display("FAIL async_instr got=%h exp=%h", de_instr, BUBBLE); end
      $display("async_reset: de_valid=%b fe_ready=%b before next edge", de_valid, fe_ready);
      fe_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL async_post got=%b exp=0", de_valid); end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; fe_valid = 1'b0; fe_pc = '0; fe_instr = '0; de_ready = 1'b0;
      test_reset();
      test_streaming();
      test_stall_full();
      test_flush();
      test_wrap_arith();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
